// File: rtl/tick_divider.sv
// Modulo-D tick divider: counts accepted ticks modulo a runtime divisor,
// giving a square wave, a wrap pulse, the live count and the active divisor.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   tick_in      single-cycle count enable from the upstream counter
//   en           run enable; ticks ignored and state held when low
//   div_in       requested divisor (0 is ignored)
//   div_load     one-cycle strobe requesting div_in as the divisor
//   count        current count, 0..div_cur-1
//   sq_out       registered square wave, high while count < ceil(D/2)
//   tc_pulse     registered one-cycle pulse after each wrapping tick
//   div_cur      divisor currently in effect
//   load_pending a new divisor waits for the next wrap
module tick_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic [WIDTH-1:0] count,
  output logic             sq_out,
  output logic             tc_pulse,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_pending
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] count_q, count_d;
  logic             sq_q, sq_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             lp_q, lp_d;

  logic             acc;
  logic             load_ok;
  logic             wrap;
  logic [WIDTH:0]   half;

  always_comb begin
    count_d = count_q;
    sq_d    = sq_q;
    tc_d    = 1'b0;
    div_d   = div_q;
    pend_d  = pend_q;
    lp_d    = lp_q;
    acc     = tick_in & en;
    load_ok = div_load & (div_in != '0);
    wrap    = acc & (count_q == (div_q - ONE));
    half    = '0;

    if (load_ok && !en) begin
      // Stopped divider: new divisor applies at once and restarts low.
      div_d   = div_in;
      count_d = '0;
      sq_d    = 1'b0;
      pend_d  = '0;
      lp_d    = 1'b0;
    end else begin
      if (acc) begin
        count_d = wrap ? '0 : count_q + ONE;
      end
      if (wrap) begin
        tc_d = 1'b1;
        // A load on the wrap edge beats any older pending value.
        if (load_ok) begin
          div_d  = div_in;
          pend_d = '0;
          lp_d   = 1'b0;
        end else if (lp_q) begin
          div_d  = pend_q;
          pend_d = '0;
          lp_d   = 1'b0;
        end
      end else if (load_ok) begin
        pend_d = div_in;
        lp_d   = 1'b1;
      end
      if (acc) begin
        // ceil(D/2) in WIDTH+1 bits so D = 2^WIDTH-1 cannot overflow.
        half = ({1'b0, div_d} + 1'b1) >> 1;
        sq_d = ({1'b0, count_d} < half);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      sq_q    <= 1'b0;
      tc_q    <= 1'b0;
      div_q   <= DEF;
      pend_q  <= '0;
      lp_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      sq_q    <= sq_d;
      tc_q    <= tc_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      lp_q    <= lp_d;
    end
  end

  assign count        = count_q;
  assign sq_out       = sq_q;
  assign tc_pulse     = tc_q;
  assign div_cur      = div_q;
  assign load_pending = lp_q;

endmodule
